// File: rtl/mac_pkg.sv
// Shared types and helpers for the product accumulator slice.
package mac_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } acc_state_t;

    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out valid/ready bundle.
interface product_accumulator_if
    import mac_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int CW    = cnt_w(8)
);

    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CW-1:0]    out_count;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_product,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_product,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_ovf
    );

endinterface

// File: rtl/sat_add.sv
// Zero-extending adder that clamps to all-ones on carry-out.
module sat_add #(
    parameter int W_A = 16,
    parameter int W_B = 8
) (
    input  logic [W_A-1:0] a,
    input  logic [W_B-1:0] b,
    output logic [W_A-1:0] sum,
    output logic           carry
);

    logic [W_A:0] s;

    assign s     = {1'b0, a} + {{(W_A + 1 - W_B){1'b0}}, b};
    assign carry = s[W_A];
    assign sum   = carry ? '1 : s[W_A-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end: sums a vector of products
// and holds the result until the consumer takes it.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int N       = 4,
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    product_accumulator_if.slave bus
);

    localparam int CW = cnt_w(MAX_LEN);

    generate
        if (ACC_W < 2 * N) begin : g_bad_acc_w
            $error("product_accumulator: ACC_W must be >= 2*N");
        end
        if (MAX_LEN < 1) begin : g_bad_max_len
            $error("product_accumulator: MAX_LEN must be >= 1");
        end
    endgenerate

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sat_sum;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             carry;
    logic             accept;

    sat_add #(
        .W_A (ACC_W),
        .W_B (2 * N)
    ) u_add (
        .a     (acc_q),
        .b     (bus.in_product),
        .sum   (sat_sum),
        .carry (carry)
    );

    assign accept        = bus.in_valid && (state_q == ACCUM);
    assign bus.in_ready  = rst_n && (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = sat_sum;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q + CW'(1);
                    // in_last on the MAX_LEN-th term still closes only once
                    if (bus.in_last || cnt_d == CW'(MAX_LEN)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
